// File: rtl/rf_pkg.sv
// rf_pkg: register-file write types shared by producers, the write queue and the register file.
package rf_pkg;
   localparam int REG_AW = 5;
   localparam int REG_DW = 32;
   typedef struct packed {
      logic [REG_AW-1:0] addr;
      logic [REG_DW-1:0] data;
   } rf_wr_t;
endpackage

// File: rtl/rf_wq_lookup.sv
// rf_wq_lookup: newest-first associative search over the live entries of the write queue.
module rf_wq_lookup #(
   parameter int DEPTH = 4,
   parameter int AW    = 5,
   parameter int DW    = 32,
   parameter int PW    = $clog2(DEPTH)
) (
   input  logic [AW-1:0] addr_q [DEPTH],
   input  logic [DW-1:0] data_q [DEPTH],
   input  logic [PW-1:0] rd_ptr,
   input  logic [PW:0]   count,
   input  logic [AW-1:0] lk_addr,
   output logic          hit,
   output logic [DW-1:0] data
);
   logic [PW-1:0] idx;
   // Walk oldest to newest so the last match, the newest write, wins; x0 never hits.
   always_comb begin
      hit  = 1'b0;
      data = '0;
      idx  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = rd_ptr + PW'(i);
         if (lk_addr != '0 && (PW+1)'(i) < count && addr_q[idx] == lk_addr) begin
            hit  = 1'b1;
            data = data_q[idx];
         end
      end
   end
endmodule

// File: rtl/rf_write_queue.sv
// rf_write_queue: ordered two-producer writeback queue draining onto the register-file write port,
// with two forwarding lookups over queued-but-unwritten values.
module rf_write_queue
   import rf_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = REG_AW,
   parameter int DW    = REG_DW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          stall,
   input  logic          m_valid,
   output logic          m_ready,
   input  logic [AW-1:0] m_addr,
   input  logic [DW-1:0] m_data,
   input  logic          a_valid,
   output logic          a_ready,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_data,
   output logic [AW-1:0] WAddr_RF,
   output logic [DW-1:0] WD_RF,
   output logic          WrEn_RF,
   input  logic [AW-1:0] lk1_addr,
   input  logic [AW-1:0] lk2_addr,
   output logic          lk1_hit,
   output logic          lk2_hit,
   output logic [DW-1:0] lk1_data,
   output logic [DW-1:0] lk2_data
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [AW-1:0] addr_q [DEPTH];
   logic [DW-1:0] data_q [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          m_res, m_en, a_en, deq;

   // M only reserves a slot ahead of A when it actually enqueues (nonzero address).
   assign m_res    = m_valid && m_addr != '0;
   assign m_ready  = count < CW'(DEPTH);
   assign a_ready  = count + CW'(m_res) < CW'(DEPTH);
   assign m_en     = m_res && m_ready;
   assign a_en     = a_valid && a_ready && a_addr != '0;
   assign WrEn_RF  = count != '0;
   assign deq      = WrEn_RF && !stall;
   assign WAddr_RF = WrEn_RF ? addr_q[rd_ptr] : '0;
   assign WD_RF    = WrEn_RF ? data_q[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + PW'(m_en) + PW'(a_en);
         rd_ptr <= rd_ptr + PW'(deq);
         count  <= count + CW'(m_en) + CW'(a_en) - CW'(deq);
      end
   end

   // M is older than A in the same cycle, so it takes the first free slot.
   always_ff @(posedge clk) begin
      if (m_en) begin
         addr_q[wr_ptr] <= m_addr;
         data_q[wr_ptr] <= m_data;
      end
      if (a_en) begin
         addr_q[wr_ptr + PW'(m_en)] <= a_addr;
         data_q[wr_ptr + PW'(m_en)] <= a_data;
      end
   end

   rf_wq_lookup #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_lk1 (
      .addr_q(addr_q), .data_q(data_q), .rd_ptr(rd_ptr), .count(count),
      .lk_addr(lk1_addr), .hit(lk1_hit), .data(lk1_data)
   );

   rf_wq_lookup #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_lk2 (
      .addr_q(addr_q), .data_q(data_q), .rd_ptr(rd_ptr), .count(count),
      .lk_addr(lk2_addr), .hit(lk2_hit), .data(lk2_data)
   );
endmodule

// File: tb/tb_rf_write_queue.sv
// tb_rf_write_queue: queue-model scoreboard checked every cycle plus hand-computed directed expectations.
module tb_rf_write_queue;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset, stall;
   logic        m_valid, m_ready, a_valid, a_ready;
   logic [4:0]  m_addr, a_addr, WAddr_RF, lk1_addr, lk2_addr;
   logic [31:0] m_data, a_data, WD_RF, lk1_data, lk2_data;
   logic        WrEn_RF, lk1_hit, lk2_hit;

   int checks = 0;
   int errors = 0;
   bit run = 1'b0;

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;
   ent_t q[$];

   always #5 clk = ~clk;

   rf_write_queue #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
      .clk(clk), .reset(reset), .stall(stall),
      .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_data(m_data),
      .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
      .WAddr_RF(WAddr_RF), .WD_RF(WD_RF), .WrEn_RF(WrEn_RF),
      .lk1_addr(lk1_addr), .lk2_addr(lk2_addr),
      .lk1_hit(lk1_hit), .lk2_hit(lk2_hit), .lk1_data(lk1_data), .lk2_data(lk2_data)
   );

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", n, act, exp, $time);
      end
   endtask

   function automatic bit mdl_m_ready();
      return q.size() < DEPTH;
   endfunction

   function automatic bit mdl_a_ready();
      return q.size() + ((m_valid && m_addr != 0) ? 1 : 0) < DEPTH;
   endfunction

   task automatic mdl_lk(input logic [4:0] ad, output logic h, output logic [31:0] d);
      h = 1'b0;
      d = '0;
      if (ad != 0)
         for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].a == ad) begin
               h = 1'b1;
               d = q[i].d;
               break;
            end
   endtask

   always @(posedge clk) begin
      bit mr, ar;
      mr = mdl_m_ready();
      ar = mdl_a_ready();
      if (reset) q.delete();
      else begin
         if (q.size() != 0 && !stall) void'(q.pop_front());
         if (m_valid && mr && m_addr != 0) q.push_back('{m_addr, m_data});
         if (a_valid && ar && a_addr != 0) q.push_back('{a_addr, a_data});
      end
   end

   always @(negedge clk) begin
      logic h;
      logic [31:0] d;
      if (run) begin
         chk("m_ready", m_ready, mdl_m_ready());
         chk("a_ready", a_ready, mdl_a_ready());
         chk("WrEn_RF", WrEn_RF, q.size() != 0);
         chk("WAddr_RF", WAddr_RF, q.size() != 0 ? q[0].a : 5'd0);
         chk("WD_RF", WD_RF, q.size() != 0 ? q[0].d : 32'd0);
         mdl_lk(lk1_addr, h, d);
         chk("lk1_hit", lk1_hit, h);
         chk("lk1_data", lk1_data, d);
         mdl_lk(lk2_addr, h, d);
         chk("lk2_hit", lk2_hit, h);
         chk("lk2_data", lk2_data, d);
      end
   end

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_m(input logic v, input logic [4:0] ad, input logic [31:0] d);
      m_valid = v; m_addr = ad; m_data = d;
   endtask

   task automatic drive_a(input logic v, input logic [4:0] ad, input logic [31:0] d);
      a_valid = v; a_addr = ad; a_data = d;
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0;
      drive_m(0, 0, 0); drive_a(0, 0, 0);
      lk1_addr = 0; lk2_addr = 0;
      step(2);
      reset = 1'b0;
      run = 1'b1;
      @(negedge clk);
      chk("reset m_ready", m_ready, 1);
      chk("reset a_ready", a_ready, 1);
      chk("reset WrEn", WrEn_RF, 0);
      chk("reset WD", WD_RF, 0);
      step();

      // single write
      drive_m(1, 5, 32'hDEADBEEF); lk1_addr = 5;
      step();
      drive_m(0, 0, 0);
      @(negedge clk);
      chk("single WrEn", WrEn_RF, 1);
      chk("single WAddr", WAddr_RF, 5);
      chk("single WD", WD_RF, 32'hDEADBEEF);
      chk("single lk hit", lk1_hit, 1);
      step();
      @(negedge clk);
      chk("single drained", WrEn_RF, 0);
      chk("single lk gone", lk1_hit, 0);
      step();

      // dual enqueue ordering
      drive_m(1, 3, 32'h11); drive_a(1, 3, 32'h22); lk1_addr = 3;
      step();
      drive_m(0, 0, 0); drive_a(0, 0, 0);
      @(negedge clk);
      chk("dual head", WD_RF, 32'h11);
      chk("dual lk newest", lk1_data, 32'h22);
      step();
      @(negedge clk);
      chk("dual second", WD_RF, 32'h22);
      chk("dual lk after", lk1_data, 32'h22);
      step();

      // x0 writes are accepted and dropped
      drive_a(1, 0, 32'hFFFF); lk1_addr = 0;
      @(negedge clk);
      chk("x0 a_ready", a_ready, 1);
      step();
      drive_a(0, 0, 0);
      @(negedge clk);
      chk("x0 WrEn", WrEn_RF, 0);
      chk("x0 lk", lk1_hit, 0);
      step();

      // full and backpressure
      stall = 1'b1; lk1_addr = 1; lk2_addr = 2;
      drive_m(1, 1, 32'hA1); drive_a(1, 2, 32'hA2);
      step();
      drive_m(1, 1, 32'hB1); drive_a(1, 2, 32'hB2);
      step();
      drive_a(0, 0, 0); drive_m(1, 9, 32'h99);
      @(negedge clk);
      chk("full m_ready", m_ready, 0);
      chk("full a_ready", a_ready, 0);
      chk("full lk1 newest", lk1_data, 32'hB1);
      step();
      stall = 1'b0;
      @(negedge clk);
      chk("drain first", WD_RF, 32'hA1);
      step();
      @(negedge clk);
      chk("reopen m_ready", m_ready, 1);
      chk("drain second", WD_RF, 32'hA2);
      step();
      drive_m(0, 0, 0);
      step(5);

      // near-full: only M accepted, A retried later
      stall = 1'b1;
      drive_m(1, 4, 32'h41); drive_a(1, 6, 32'h61);
      step();
      drive_a(0, 0, 0); drive_m(1, 7, 32'h71);
      step();
      drive_m(1, 8, 32'h81); drive_a(1, 10, 32'hA0);
      @(negedge clk);
      chk("near m_ready", m_ready, 1);
      chk("near a_ready", a_ready, 0);
      step();
      drive_m(0, 0, 0);
      stall = 1'b0;
      @(negedge clk);
      chk("near a held", a_ready, 0);
      step();
      @(negedge clk);
      chk("near a reopen", a_ready, 1);
      step();
      drive_a(0, 0, 0); lk2_addr = 10;
      @(negedge clk);
      chk("near a queued", lk2_data, 32'hA0);
      step(6);

      // reset mid-drain
      stall = 1'b1;
      drive_m(1, 11, 32'hC1); drive_a(1, 12, 32'hC2);
      step();
      drive_a(0, 0, 0); drive_m(1, 13, 32'hC3);
      step();
      drive_m(0, 0, 0); stall = 1'b0;
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      @(negedge clk);
      chk("rst WrEn", WrEn_RF, 0);
      chk("rst m_ready", m_ready, 1);
      chk("rst a_ready", a_ready, 1);
      for (int i = 0; i < 3; i++) begin
         step();
         @(negedge clk);
         chk("rst no write", WrEn_RF, 0);
      end
      step(2);
      run = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
